// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared register map, STATUS bit positions and FSM state type for
//          the memory-mapped UART.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    // Register offsets on the 2-bit reg_addr bus
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    // STATUS register bit positions
    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_EMPTY   = 2;
    localparam int STAT_TX_DROP    = 3;
    localparam int STAT_RX_OVERRUN = 4;

    // CTRL register bit positions
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Common state encoding for the TX and RX machines
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_mmio_if.sv
//------------------------------------------------------------------------------
// Module : uart_mmio_if
// Brief  : CPU data-bus slice seen by the UART: chip-select, register offset,
//          read/write strobes and 16-bit data in both directions.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_mmio_if;

    logic        cs;
    logic [1:0]  reg_addr;
    logic        wr;
    logic        rd;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    // CPU / address decoder side
    modport master (
        output cs,
        output reg_addr,
        output wr,
        output rd,
        output wr_data,
        input  rd_data
    );

    // UART side
    modport slave (
        input  cs,
        input  reg_addr,
        input  wr,
        input  rd,
        input  wr_data,
        output rd_data
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Single-clock first-word-fall-through FIFO. Pointers carry one
//          extra wrap bit so full and empty are distinguishable without a
//          separate counter. Simultaneous push and pop is legal at any level.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when it is popped at the same time.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = r_mem[r_rptr[AW-1:0]];

    // Read/write pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array, no reset needed: contents are only visible when non-empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
//------------------------------------------------------------------------------
// Module : uart_mmio
// Brief  : Memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags, a
//          level interrupt and BRAM-style one-cycle registered read data.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 27_000_000,
    parameter int BAUD     = 115_200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_mmio_if.slave bus,
    output logic       txd,
    input  wire logic  rxd,
    output logic       irq
);

    localparam int DIV   = CLOCK_HZ / BAUD;
    localparam int CNT_W = (DIV > 4) ? $clog2(DIV) : 2;

    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(DIV / 2 - 1);

    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_mmio: CLOCK_HZ / BAUD must be at least 4");
        end
    endgenerate

    // ---------------------------------------------------------------- bus decode
    logic w_sel_wr, w_sel_rd;
    logic w_data_wr, w_stat_wr, w_ctrl_wr, w_data_rd;

    // A read strobe together with a write strobe is treated as a write only
    assign w_sel_wr  = bus.cs & bus.wr;
    assign w_sel_rd  = bus.cs & bus.rd & ~bus.wr;
    assign w_data_wr = w_sel_wr && (bus.reg_addr == UART_REG_DATA);
    assign w_stat_wr = w_sel_wr && (bus.reg_addr == UART_REG_STATUS);
    assign w_ctrl_wr = w_sel_wr && (bus.reg_addr == UART_REG_CTRL);
    assign w_data_rd = w_sel_rd && (bus.reg_addr == UART_REG_DATA);

    logic [7:0] w_unused_wr_hi;
    assign w_unused_wr_hi = bus.wr_data[15:8];

    // ---------------------------------------------------------------- FIFOs
    logic       w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0] w_tx_dout;
    logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0] w_rx_dout;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_data_wr),
        .pop   (w_tx_pop),
        .din   (bus.wr_data[7:0]),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    logic [7:0] r_rx_shift;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (r_rx_shift),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // ---------------------------------------------------------------- TX path
    uart_state_t      r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_txd;
    logic             w_tx_line;
    logic             w_tx_busy;
    logic             w_tx_drop;

    // The shifter takes a byte when idle, or at the end of a stop bit so that
    // queued bytes go out back to back without an idle bit in between.
    assign w_tx_pop  = ~w_tx_empty &
                       ((r_tx_state == IDLE) ||
                        ((r_tx_state == STOP) && (r_tx_cnt == c_DIV_LAST)));
    assign w_tx_busy = (r_tx_state != IDLE) | ~w_tx_empty;
    assign w_tx_drop = w_data_wr & w_tx_full & ~w_tx_pop;

    // Line level implied by the current TX state
    always_comb begin
        w_tx_line = 1'b1;
        case (r_tx_state)
            START:   w_tx_line = 1'b0;
            DATA:    w_tx_line = r_tx_shift[0];
            default: w_tx_line = 1'b1;
        endcase
    end

    // TX state machine: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    r_tx_cnt <= '0;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_dout;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (r_tx_cnt == c_DIV_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tx_cnt == c_DIV_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        if (r_tx_bit == 3'd7) r_tx_state <= STOP;
                        else                  r_tx_bit   <= r_tx_bit + 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_tx_cnt == c_DIV_LAST) begin
                        r_tx_cnt <= '0;
                        if (!w_tx_empty) begin
                            r_tx_shift <= w_tx_dout;
                            r_tx_state <= START;
                        end else begin
                            r_tx_state <= IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    // Registered serial output, forced idle-high by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_txd <= 1'b1;
        else      r_txd <= w_tx_line;
    end

    assign txd = r_txd;

    // ---------------------------------------------------------------- RX path
    logic             r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t      r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic             w_rx_ovr;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_push = (r_rx_state == STOP) && (r_rx_cnt == c_DIV_LAST) && r_rx_s2;
    assign w_rx_pop  = w_data_rd & ~w_rx_empty;
    assign w_rx_ovr  = w_rx_push & w_rx_full & ~w_rx_pop;

    // RX state machine. After a framing error it drops straight to IDLE; since
    // IDLE waits for a falling edge, nothing restarts until the line has been
    // high again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_s2) r_rx_state <= START;
                end
                START: begin
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? IDLE : DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_rx_cnt == c_DIV_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= STOP;
                        else                  r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_rx_cnt == c_DIV_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- registers
    logic [1:0]  r_ctrl;
    logic        r_tx_drop;
    logic        r_rx_ovr;
    logic [15:0] r_rd_data;
    logic        r_irq;
    logic [4:0]  w_status;

    always_comb begin
        w_status                  = '0;
        w_status[STAT_TX_BUSY]    = w_tx_busy;
        w_status[STAT_TX_FULL]    = w_tx_full;
        w_status[STAT_RX_EMPTY]   = w_rx_empty;
        w_status[STAT_TX_DROP]    = r_tx_drop;
        w_status[STAT_RX_OVERRUN] = r_rx_ovr;
    end

    // CTRL and sticky flags; a new error in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl    <= '0;
            r_tx_drop <= 1'b0;
            r_rx_ovr  <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= bus.wr_data[1:0];
            if (w_stat_wr && bus.wr_data[STAT_TX_DROP])    r_tx_drop <= 1'b0;
            if (w_stat_wr && bus.wr_data[STAT_RX_OVERRUN]) r_rx_ovr  <= 1'b0;
            if (w_tx_drop) r_tx_drop <= 1'b1;
            if (w_rx_ovr)  r_rx_ovr  <= 1'b1;
        end
    end

    // Registered read data, one cycle after the strobe; holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (w_sel_rd) begin
            case (bus.reg_addr)
                UART_REG_DATA:   r_rd_data <= w_rx_empty ? 16'h0000 : {7'b0, 1'b1, w_rx_dout};
                UART_REG_STATUS: r_rd_data <= {11'b0, w_status};
                UART_REG_CTRL:   r_rd_data <= {14'b0, r_ctrl};
                default:         r_rd_data <= 16'h0000;
            endcase
        end
    end

    // Level interrupt from RX data available and TX drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_irq <= 1'b0;
        else      r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & ~w_rx_empty) |
                           (r_ctrl[CTRL_TX_IRQ_EN] & ~w_tx_busy);
    end

    assign bus.rd_data = r_rd_data;
    assign irq         = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
//------------------------------------------------------------------------------
// Module : tb_uart_mmio
// Brief  : Directed self-checking bench for uart_mmio (DIV = 10, depth 4).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_mmio;

    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rxd_drv;
    logic loop_en;
    logic txd;
    logic irq;
    wire  w_rxd = loop_en ? txd : rxd_drv;

    int checks = 0;
    int errors = 0;

    uart_mmio_if bus ();

    uart_mmio #(
        .CLOCK_HZ (100_000),
        .BAUD     (10_000),
        .TX_DEPTH (4),
        .RX_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .txd (txd),
        .rxd (w_rxd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
        bus.cs       = 1'b1;
        bus.wr       = 1'b1;
        bus.reg_addr = addr;
        bus.wr_data  = data;
        tick();
        bus.cs = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [15:0] data);
        bus.cs       = 1'b1;
        bus.rd       = 1'b1;
        bus.reg_addr = addr;
        tick();
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        data   = bus.rd_data;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (10) tick();
        end
        rxd_drv = stop_bit;
        repeat (10) tick();
        rxd_drv = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  pat;
        logic [7:0]  q [5];
        int          lows;

        rst          = 1'b0;
        rxd_drv      = 1'b1;
        loop_en      = 1'b0;
        bus.cs       = 1'b0;
        bus.wr       = 1'b0;
        bus.rd       = 1'b0;
        bus.reg_addr = 2'd0;
        bus.wr_data  = 16'h0000;

        // ---------------- reset
        repeat (3) tick();
        check("rst_txd", {15'b0, txd}, 16'h0001);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_rd_data", bus.rd_data, 16'h0000);
        rst = 1'b1;
        tick();
        bus_read(UART_REG_STATUS, rd);
        check("rst_status", rd, 16'h0004);

        // ---------------- TX single byte 0x41
        pat = 8'h41;
        bus_write(UART_REG_DATA, 16'h0041);          // edge N
        check("tx1_n1_high", {15'b0, txd}, 16'h0001);
        tick();                                      // edge N+1
        check("tx1_n1_high", {15'b0, txd}, 16'h0001);
        tick();                                      // edge N+2
        check("tx1_start_edge", {15'b0, txd}, 16'h0000);
        repeat (5) tick();                           // mid start bit
        check("tx1_start_mid", {15'b0, txd}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            repeat (10) tick();
            check("tx1_data_bit", {15'b0, txd}, {15'b0, pat[i]});
        end
        repeat (10) tick();
        check("tx1_stop", {15'b0, txd}, 16'h0001);
        repeat (6) tick();
        bus_read(UART_REG_STATUS, rd);
        check("tx1_not_busy", rd, 16'h0004);

        // ---------------- TX back-to-back and overflow
        for (int i = 0; i < 6; i++) begin
            bus_write(UART_REG_DATA, 16'(i + 1));
        end
        bus_read(UART_REG_STATUS, rd);                   // edge N+6
        check("b2b_full_drop", rd, 16'h000F);
        tick();                                          // N+7: mid start of frame 0
        for (int k = 0; k < 5; k++) begin
            check("b2b_start_bit", {15'b0, txd}, 16'h0000);
            repeat (10) tick();
            check("b2b_bit0", {15'b0, txd}, ((k % 2) == 0) ? 16'h0001 : 16'h0000);
            repeat (90) tick();
        end
        check("b2b_idle_after", {15'b0, txd}, 16'h0001);
        bus_read(UART_REG_STATUS, rd);
        check("b2b_drop_sticky", rd, 16'h000C);
        bus_write(UART_REG_STATUS, 16'h0008);
        bus_read(UART_REG_STATUS, rd);
        check("b2b_drop_clear", rd, 16'h0004);

        // ---------------- RX loopback
        loop_en = 1'b1;
        bus_write(UART_REG_CTRL, 16'h0001);
        bus_read(UART_REG_CTRL, rd);
        check("ctrl_readback", rd, 16'h0001);
        check("lb_irq_low", {15'b0, irq}, 16'h0000);
        bus_write(UART_REG_DATA, 16'h005A);
        for (int i = 0; i < 300; i++) begin
            if (irq) break;
            tick();
        end
        check("lb_irq_rise", {15'b0, irq}, 16'h0001);
        bus_read(UART_REG_DATA, rd);
        check("lb_data", rd, 16'h015A);
        bus_read(UART_REG_DATA, rd);
        check("lb_data_empty", rd, 16'h0000);
        check("lb_irq_fall", {15'b0, irq}, 16'h0000);
        loop_en = 1'b0;
        bus_write(UART_REG_CTRL, 16'h0000);

        // ---------------- RX overrun
        q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33; q[3] = 8'h44; q[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_byte(q[i], 1'b1);
        bus_read(UART_REG_STATUS, rd);
        check("ovr_status", rd, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            bus_read(UART_REG_DATA, rd);
            check("ovr_fifo_data", rd, {8'h01, q[i]});
        end
        bus_read(UART_REG_DATA, rd);
        check("ovr_fifo_drained", rd, 16'h0000);
        bus_write(UART_REG_STATUS, 16'h0010);
        bus_read(UART_REG_STATUS, rd);
        check("ovr_clear", rd, 16'h0004);

        // ---------------- RX framing error and glitch
        send_byte(8'hA5, 1'b0);
        repeat (10) tick();
        bus_read(UART_REG_STATUS, rd);
        check("frame_err_drop", rd, 16'h0004);
        rxd_drv = 1'b0;
        repeat (3) tick();
        rxd_drv = 1'b1;
        repeat (30) tick();
        bus_read(UART_REG_STATUS, rd);
        check("glitch_ignored", rd, 16'h0004);
        send_byte(8'h3C, 1'b1);
        bus_read(UART_REG_DATA, rd);
        check("rx_after_glitch", rd, 16'h013C);

        // ---------------- mid-frame reset
        bus_write(UART_REG_DATA, 16'h0000);          // edge N
        bus_write(UART_REG_DATA, 16'h0000);          // edge N+1, queued
        repeat (36) tick();                          // cycle 35 of the frame
        check("mid_txd_low", {15'b0, txd}, 16'h0000);
        rst = 1'b0;
        #1;
        check("mid_rst_txd", {15'b0, txd}, 16'h0001);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bus_read(UART_REG_STATUS, rd);
        check("mid_rst_status", rd, 16'h0004);
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (!txd) lows++;
        end
        check("mid_no_frames", 16'(lows), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
